// File: rtl/cnt_rr_sched.sv
// cnt_rr_sched: round-robin scheduler in front of a shared CW-bit step counter.
//
// Each of NREQ requesters raises req[i] with step2[i] selecting a +2 (1) or
// +1 (0) increment. One requester is granted per cycle, searching upward from
// the round-robin pointer. The counter is updated on the granting edge. After
// each grant the pointer moves to the slot just past the winner.
//
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   en      - scheduler enable; no grants while low
//   clr     - synchronous clear of counter and overflow flag (highest priority)
//   req     - per-requester increment request (level, held until granted)
//   step2   - per-requester step select, sampled together with req
//   gnt     - one-hot grant, combinational, same cycle as req
//   cnt_o   - registered counter value
//   ovf_o   - sticky overflow flag, registered
//   busy_o  - en & |req, combinational
//
// Build option:
//   CNT_RR_SCHED_SAT_EN - when defined, the counter saturates at 2^CW-1
//                         instead of wrapping; ovf_o is set in both modes.

module cnt_rr_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned CW   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            clr,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] step2,
    output logic [NREQ-1:0] gnt,
    output logic [CW-1:0]   cnt_o,
    output logic            ovf_o,
    output logic            busy_o
);

    localparam int unsigned PW = $clog2(NREQ);

    logic [PW-1:0]   ptr;
    logic [CW-1:0]   cnt_q;
    logic            ovf_q;

    logic            hit;
    logic [PW-1:0]   gidx;
    logic [PW-1:0]   cand;
    logic [NREQ-1:0] gnt_c;
    logic [CW:0]     sum;

    // Rotating priority search starting at ptr. Gating with rst_n keeps gnt
    // low for the whole time reset is held, not just after the first edge.
    always_comb begin
        gnt_c = '0;
        gidx  = '0;
        cand  = '0;
        hit   = 1'b0;
        if (rst_n && en && !clr) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                cand = PW'((32'(ptr) + k) % NREQ);
                if (!hit && req[cand]) begin
                    hit  = 1'b1;
                    gidx = cand;
                end
            end
        end
        if (hit) begin
            gnt_c[gidx] = 1'b1;
        end
    end

    // One extra bit so the carry out marks a wrap/overflow event.
    always_comb begin
        sum = {1'b0, cnt_q} + (step2[gidx] ? (CW+1)'(2) : (CW+1)'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            ptr   <= '0;
        end else if (clr) begin
            // Pointer deliberately left alone so fairness survives a clear.
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (hit) begin
            ptr <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            if (sum[CW]) begin
                ovf_q <= 1'b1;
`ifdef CNT_RR_SCHED_SAT_EN
                cnt_q <= '1;
`else
                cnt_q <= sum[CW-1:0];
`endif
            end else begin
                cnt_q <= sum[CW-1:0];
            end
        end
    end

    assign gnt    = gnt_c;
    assign cnt_o  = cnt_q;
    assign ovf_o  = ovf_q;
    assign busy_o = en & (|req);

endmodule

// File: tb/tb_cnt_rr_sched.sv
// tb_cnt_rr_sched: directed self-checking bench for cnt_rr_sched (NREQ=4, CW=4).
// A reference model of the scheduler is checked against the DUT on every
// falling edge. Directed steps also compare against hand-computed literals.
// The same file covers wrap mode and saturating mode (CNT_RR_SCHED_SAT_EN).

module tb_cnt_rr_sched;

    localparam int N = 4;
    localparam int W = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         clr;
    logic [N-1:0] req;
    logic [N-1:0] step2;
    logic [N-1:0] gnt;
    logic [W-1:0] cnt_o;
    logic         ovf_o;
    logic         busy_o;

    int checks = 0;
    int errors = 0;

    // Model state
    int mcnt = 0;
    int movf = 0;
    int mptr = 0;

    cnt_rr_sched #(.NREQ(N), .CW(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .clr    (clr),
        .req    (req),
        .step2  (step2),
        .gnt    (gnt),
        .cnt_o  (cnt_o),
        .ovf_o  (ovf_o),
        .busy_o (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Winner index by model rules, or -1 when nothing is granted
    function automatic int pick();
        if (!rst_n || !en || clr) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (mptr + k) % N;
            if (((req >> i) & 4'd1) != 4'd0) return i;
        end
        return -1;
    endfunction

    function automatic int exp_gnt();
        int i;
        i = pick();
        return (i < 0) ? 0 : (1 << i);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int i;
        int s;
        if (!rst_n) begin
            mcnt <= 0;
            movf <= 0;
            mptr <= 0;
        end else if (clr) begin
            mcnt <= 0;
            movf <= 0;
        end else begin
            i = pick();
            if (i >= 0) begin
                s = mcnt + ((((step2 >> i) & 4'd1) != 4'd0) ? 2 : 1);
                if (s > MAXV) begin
                    movf <= 1;
`ifdef CNT_RR_SCHED_SAT_EN
                    mcnt <= MAXV;
`else
                    mcnt <= s - (MAXV + 1);
`endif
                end else begin
                    mcnt <= s;
                end
                mptr <= (i + 1) % N;
            end
        end
    end

    always @(negedge clk) begin
        check("m_gnt",  32'(gnt),    32'(exp_gnt()));
        check("m_cnt",  32'(cnt_o),  32'(mcnt));
        check("m_ovf",  32'(ovf_o),  32'(movf));
        check("m_busy", 32'(busy_o), 32'((en && req != 0) ? 1 : 0));
    end

    task automatic drive(input logic e, input logic c, input logic [N-1:0] r, input logic [N-1:0] s);
        en = e; clr = c; req = r; step2 = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin : stim
        int g3 [8];
        g3 = '{1, 2, 4, 8, 1, 2, 4, 8};
        rst_n = 1'b1;
        drive(0, 0, 0, 0);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_cnt", 32'(cnt_o), 0);
        check("rst_ovf", 32'(ovf_o), 0);
        check("rst_gnt", 32'(gnt), 0);
        rst_n = 1'b1;

        // single requester, +1 three times
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, 4'b0001, 4'b0000);
            #1;
            check("t2_gnt", 32'(gnt), 1);
            check("t2_cnt", 32'(cnt_o), 32'(c));
            tick();
        end
        drive(1, 0, 4'b0000, 4'b0000);
        #1;
        check("t2_cnt_end", 32'(cnt_o), 3);
        check("t2_ovf", 32'(ovf_o), 0);
        check("t2_busy_idle", 32'(busy_o), 0);
        tick();

        // bring ptr back to 0, then clear (clear suppresses grant)
        drive(1, 0, 4'b1000, 4'b0000);
        #1 check("t3_pre_gnt", 32'(gnt), 8);
        tick();
        drive(1, 1, 4'b1111, 4'b0000);
        #1 check("t3_clr_gnt", 32'(gnt), 0);
        tick();

        // all requesting: strict rotation
        for (int k = 0; k < 8; k++) begin
            drive(1, 0, 4'b1111, 4'b0000);
            #1;
            check("t3_gnt", 32'(gnt), 32'(g3[k]));
            check("t3_cnt", 32'(cnt_o), 32'(k));
            tick();
        end
        drive(1, 0, 4'b0000, 4'b0000);
        #1 check("t3_cnt_end", 32'(cnt_o), 8);

        // climb to 14 with +2 steps from requester 0 (ptr ends at 1)
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 4'b0001, 4'b0001);
            tick();
        end
        drive(1, 0, 4'b0010, 4'b0010);
        #1;
        check("t4_cnt14", 32'(cnt_o), 14);
        check("t4_gnt", 32'(gnt), 2);
        tick();
        drive(1, 0, 4'b0100, 4'b0000);
        #1;
`ifdef CNT_RR_SCHED_SAT_EN
        check("t4_cnt_ovf", 32'(cnt_o), 15);
`else
        check("t4_cnt_ovf", 32'(cnt_o), 0);
`endif
        check("t4_ovf", 32'(ovf_o), 1);
        check("t4_gnt2", 32'(gnt), 4);
        tick();
        drive(1, 0, 4'b0000, 4'b0000);
        #1;
`ifdef CNT_RR_SCHED_SAT_EN
        check("t4_cnt_after", 32'(cnt_o), 15);
`else
        check("t4_cnt_after", 32'(cnt_o), 1);
`endif
        check("t4_ovf_sticky", 32'(ovf_o), 1);

        // reach cnt=5 (wrap) with ptr=2, then clear with requests pending
        drive(1, 0, 4'b0001, 4'b0001);
        tick();
        drive(1, 0, 4'b0010, 4'b0010);
        tick();
        drive(1, 1, 4'b0101, 4'b0000);
        #1;
`ifdef CNT_RR_SCHED_SAT_EN
        check("t5_cnt_pre", 32'(cnt_o), 15);
`else
        check("t5_cnt_pre", 32'(cnt_o), 5);
`endif
        check("t5_ovf_pre", 32'(ovf_o), 1);
        check("t5_clr_gnt", 32'(gnt), 0);
        tick();
        drive(1, 0, 4'b0101, 4'b0000);
        #1;
        check("t5_cnt_clr", 32'(cnt_o), 0);
        check("t5_ovf_clr", 32'(ovf_o), 0);
        check("t5_ptr_kept", 32'(gnt), 4);
        tick();

        // disabled scheduler holds everything; then resumes from ptr=1
        drive(1, 0, 4'b0001, 4'b0000);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 4'b1010, 4'b0000);
            #1;
            check("t6_gnt_off", 32'(gnt), 0);
            check("t6_busy_off", 32'(busy_o), 0);
            check("t6_cnt_hold", 32'(cnt_o), 2);
            tick();
        end
        drive(1, 0, 4'b1010, 4'b0000);
        #1;
        check("t6_gnt_a", 32'(gnt), 2);
        check("t6_busy_on", 32'(busy_o), 1);
        tick();
        drive(1, 0, 4'b1010, 4'b0000);
        #1;
        check("t6_gnt_b", 32'(gnt), 8);
        check("t6_cnt", 32'(cnt_o), 3);
        tick();
        drive(1, 0, 4'b0000, 4'b0000);
        #1 check("t6_cnt_end", 32'(cnt_o), 4);

        // build cnt=9 with ovf=1 (wrap), then reset mid-cycle
        for (int k = 0; k < 8; k++) begin
            drive(1, 0, 4'b1111, 4'b1111);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 4'b1111, 4'b0000);
            tick();
        end
        drive(1, 0, 4'b1111, 4'b0000);
        #1;
`ifdef CNT_RR_SCHED_SAT_EN
        check("t1_cnt_pre", 32'(cnt_o), 15);
`else
        check("t1_cnt_pre", 32'(cnt_o), 9);
`endif
        check("t1_ovf_pre", 32'(ovf_o), 1);
        #1 rst_n = 1'b0;
        #1;
        check("t1_cnt_rst", 32'(cnt_o), 0);
        check("t1_ovf_rst", 32'(ovf_o), 0);
        check("t1_gnt_rst", 32'(gnt), 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1 check("t1_first_gnt", 32'(gnt), 1);
        tick();
        #1;
        check("t1_cnt_after", 32'(cnt_o), 1);
        check("t1_gnt_next", 32'(gnt), 2);
        drive(1, 0, 4'b0000, 4'b0000);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

endmodule
